// File: rtl/demux_scheduler.sv
// Single-entry demultiplexer: routes an upstream stream to one of eight channels,
// either a fixed channel or round-robin over enabled channels in bursts.
module demux_scheduler #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              mode,
   input  logic [2:0]        fixed_sel,
   input  logic [3:0]        burst_len,
   input  logic [7:0]        ch_en,
   input  logic [7:0]        out_ready,
   output logic [7:0]        out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [2:0]        sel,
   output logic              busy
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t            state_q;
   logic [2:0]        sel_q;
   logic [3:0]        cnt_q;
   logic              mode_q;
   logic              hold_v_q;
   logic [DATA_W-1:0] hold_data_q;
   logic [2:0]        hold_ch_q;

   logic       out_xfer, in_xfer, burst_done, leave;
   logic [3:0] eff_burst;
   logic [2:0] rr_first, rr_next;

   // Lowest wrapped offset from 'from' whose channel is enabled; incl selects
   // whether 'from' itself is a candidate. Falls back to 'from' if none found.
   function automatic logic [2:0] next_en(input logic [7:0] en, input logic [2:0] from,
                                          input logic incl);
      logic [2:0] res, idx;
      res = from;
      for (int k = 7; k >= 0; k--) begin
         idx = from + 3'(k) + (incl ? 3'd0 : 3'd1);
         if (en[idx]) res = idx;
      end
      return res;
   endfunction

   assign out_xfer   = hold_v_q && out_ready[hold_ch_q];
   assign in_ready   = (state_q == ACTIVE) && (!hold_v_q || out_xfer);
   assign in_xfer    = in_valid && in_ready;
   assign eff_burst  = (burst_len == 4'd0) ? 4'd1 : burst_len;
   // '>=' rather than '==' so a burst_len shrunk mid-burst rotates on the next word
   assign burst_done = ({1'b0, cnt_q} + 5'd1) >= {1'b0, eff_burst};
   assign leave      = !ch_en[sel_q] || (!mode && (fixed_sel != sel_q)) || (mode != mode_q);
   assign rr_first   = next_en(ch_en, sel_q, 1'b1);
   assign rr_next    = next_en(ch_en, sel_q, 1'b0);

   assign out_valid = hold_v_q ? (8'h01 << hold_ch_q) : 8'h00;
   assign out_data  = hold_data_q;
   assign busy      = hold_v_q;
   assign sel       = sel_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= 3'd0;
         cnt_q   <= 4'd0;
         mode_q  <= 1'b0;
      end else begin
         mode_q <= mode;
         case (state_q)
            IDLE: begin
               cnt_q <= 4'd0;
               if (!mode && ch_en[fixed_sel]) begin
                  state_q <= ACTIVE;
                  sel_q   <= fixed_sel;
               end else if (mode && (ch_en != 8'h00)) begin
                  state_q <= ACTIVE;
                  sel_q   <= rr_first;
               end
            end
            ACTIVE: begin
               if (leave) begin
                  state_q <= IDLE;
                  cnt_q   <= 4'd0;
               end else if (!mode) begin
                  cnt_q <= 4'd0;
               end else if (in_xfer) begin
                  if (burst_done) begin
                     cnt_q <= 4'd0;
                     sel_q <= rr_next;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
            end
         endcase
      end
   end

   // Holding register: a simultaneous load and drain reloads with no bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_v_q    <= 1'b0;
         hold_data_q <= '0;
         hold_ch_q   <= 3'd0;
      end else if (in_xfer) begin
         hold_v_q    <= 1'b1;
         hold_data_q <= in_data;
         hold_ch_q   <= sel_q;
      end else if (out_xfer) begin
         hold_v_q    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_demux_scheduler.sv
// Self-checking bench for demux_scheduler: scoreboard of expected (channel, data)
// pairs pushed on input acceptance and popped on each output transfer.
module tb_demux_scheduler;

   typedef struct packed {
      logic [2:0] ch;
      logic [7:0] data;
   } exp_t;

   logic       clk, rst;
   logic       in_valid, in_ready, mode, busy;
   logic [7:0] in_data, out_data, ch_en, out_ready, out_valid;
   logic [2:0] fixed_sel, sel;
   logic [3:0] burst_len;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   demux_scheduler #(.DATA_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mode(mode), .fixed_sel(fixed_sel), .burst_len(burst_len), .ch_en(ch_en),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .sel(sel),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Output-side scoreboard check on every observed transfer
   always @(negedge clk) begin
      if (!rst && ((out_valid & out_ready) != 8'h00)) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL out_unexpected: out_valid=%h data=%h, required no transfer", out_valid, out_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (out_valid !== (8'h01 << e.ch) || out_data !== e.data) begin
               bad++;
               $display("FAIL out_xfer: out_valid=%h data=%h, required out_valid=%h data=%h",
                        out_valid, out_data, 8'h01 << e.ch, e.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Returns at a negedge with in_ready high, or reports a timeout
   task automatic wait_ready();
      bit ok = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            ok = 1;
            break;
         end
         step();
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL wait_ready: in_ready=%b, required 1 within 8 cycles", in_ready);
      end
   endtask

   task automatic drain_check(input string name);
      step(); @(negedge clk);
      step(); @(negedge clk);
      total++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s_drain: pending=%0d busy=%b, required 0 and 0", name, sb.size(), busy);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if (out_valid !== 8'h00 || out_data !== 8'h00 || in_ready !== 1'b0 || busy !== 1'b0 || sel !== 3'd0) begin
         bad++;
         $display("FAIL reset_state: ov=%h od=%h ir=%b busy=%b sel=%0d, required all 0",
                  out_valid, out_data, in_ready, busy, sel);
      end
      step();
   endtask

   task automatic test_fixed();
      mode = 1'b0; fixed_sel = 3'd5; ch_en = 8'hFF; out_ready = 8'hFF; burst_len = 4'd1;
      in_valid = 1'b1; in_data = 8'd1;
      do_reset();
      wait_ready();
      for (int k = 0; k < 4; k++) begin
         if (k < 3) begin
            total++;
            if (in_ready !== 1'b1 || sel !== 3'd5) begin
               bad++;
               $display("FAIL fixed_in: in_ready=%b sel=%0d, required 1 and 5", in_ready, sel);
            end
            sb.push_back('{ch: 3'd5, data: 8'(k + 1)});
         end
         if (k > 0) begin
            total++;
            if (out_valid !== 8'h20) begin
               bad++;
               $display("FAIL fixed_ov: out_valid=%h, required 20", out_valid);
            end
         end
         step();
         in_data = 8'(k + 2);
         if (k == 2) in_valid = 1'b0;
         @(negedge clk);
      end
      total++;
      if (out_valid !== 8'h00) begin
         bad++;
         $display("FAIL fixed_end: out_valid=%h, required 00", out_valid);
      end
      drain_check("fixed");
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_ch [8] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd7, 3'd7, 3'd0, 3'd0};
      mode = 1'b1; burst_len = 4'd2; ch_en = 8'b1000_0101; out_ready = 8'hFF;
      in_valid = 1'b1; in_data = 8'h10;
      do_reset();
      wait_ready();
      for (int i = 0; i < 8; i++) begin
         total++;
         if (in_ready !== 1'b1 || sel !== exp_ch[i]) begin
            bad++;
            $display("FAIL rr_word%0d: in_ready=%b sel=%0d, required 1 and %0d", i, in_ready, sel, exp_ch[i]);
         end
         sb.push_back('{ch: exp_ch[i], data: 8'(8'h10 + i)});
         step();
         in_data = 8'(8'h11 + i);
         if (i == 7) in_valid = 1'b0;
         @(negedge clk);
      end
      drain_check("rr");
   endtask

   task automatic test_backpressure();
      mode = 1'b0; fixed_sel = 3'd3; ch_en = 8'hFF; out_ready = 8'hF7;
      in_valid = 1'b1; in_data = 8'hA1;
      do_reset();
      wait_ready();
      sb.push_back('{ch: 3'd3, data: 8'hA1});
      step(); in_data = 8'hB2; @(negedge clk);
      for (int j = 0; j < 3; j++) begin
         total++;
         if (out_valid !== 8'h08 || out_data !== 8'hA1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold%0d: ov=%h od=%h ir=%b, required 08 a1 0", j, out_valid, out_data, in_ready);
         end
         step();
         if (j == 2) out_ready = 8'hFF;
         @(negedge clk);
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_release: in_ready=%b, required 1", in_ready);
      end
      sb.push_back('{ch: 3'd3, data: 8'hB2});
      step(); in_valid = 1'b0; @(negedge clk);
      total++;
      if (out_valid !== 8'h08 || out_data !== 8'hB2) begin
         bad++;
         $display("FAIL bp_reload: ov=%h od=%h, required 08 b2", out_valid, out_data);
      end
      drain_check("bp");
   endtask

   task automatic test_disable();
      mode = 1'b1; burst_len = 4'd4; ch_en = 8'hFF; out_ready = 8'hFF;
      in_valid = 1'b1; in_data = 8'h31;
      do_reset();
      wait_ready();
      total++;
      if (sel !== 3'd0) begin
         bad++;
         $display("FAIL dis_start: sel=%0d, required 0", sel);
      end
      sb.push_back('{ch: 3'd0, data: 8'h31});
      step(); ch_en = 8'hFE; in_data = 8'h32; @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL dis_same_cycle: in_ready=%b, required 1", in_ready);
      end
      sb.push_back('{ch: 3'd0, data: 8'h32});
      step(); in_data = 8'h33; @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 8'h01 || out_data !== 8'h32) begin
         bad++;
         $display("FAIL dis_idle: ir=%b ov=%h od=%h, required 0 01 32", in_ready, out_valid, out_data);
      end
      step(); @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || sel !== 3'd1) begin
         bad++;
         $display("FAIL dis_reacquire: ir=%b sel=%0d, required 1 and 1", in_ready, sel);
      end
      sb.push_back('{ch: 3'd1, data: 8'h33});
      step(); in_valid = 1'b0;
      drain_check("dis");
   endtask

   task automatic test_corner();
      logic [2:0] exp_ch [4] = '{3'd1, 3'd4, 3'd1, 3'd4};
      mode = 1'b1; burst_len = 4'd0; ch_en = 8'b0001_0010; out_ready = 8'hFF;
      in_valid = 1'b1; in_data = 8'h40;
      do_reset();
      wait_ready();
      for (int i = 0; i < 4; i++) begin
         total++;
         if (sel !== exp_ch[i]) begin
            bad++;
            $display("FAIL burst0_word%0d: sel=%0d, required %0d", i, sel, exp_ch[i]);
         end
         sb.push_back('{ch: exp_ch[i], data: 8'(8'h40 + i)});
         step();
         in_data = 8'(8'h41 + i);
         if (i == 3) begin
            in_valid = 1'b0;
            ch_en = 8'h00;
         end
         @(negedge clk);
      end
      step(); in_valid = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         total++;
         if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL chen0_idle%0d: in_ready=%b, required 0", j, in_ready);
         end
         step();
      end
      in_valid = 1'b0;
      drain_check("corner");
   endtask

   task automatic test_burst_change();
      logic [2:0] exp_ch [5] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
      mode = 1'b1; burst_len = 4'd4; ch_en = 8'hFF; out_ready = 8'hFF;
      in_valid = 1'b1; in_data = 8'h50;
      do_reset();
      wait_ready();
      for (int i = 0; i < 5; i++) begin
         total++;
         if (in_ready !== 1'b1 || sel !== exp_ch[i]) begin
            bad++;
            $display("FAIL bl_word%0d: ir=%b sel=%0d, required 1 and %0d", i, in_ready, sel, exp_ch[i]);
         end
         sb.push_back('{ch: exp_ch[i], data: 8'(8'h50 + i)});
         step();
         in_data = 8'(8'h51 + i);
         if (i == 2) burst_len = 4'd2;
         if (i == 4) in_valid = 1'b0;
         @(negedge clk);
      end
      drain_check("bl");
   endtask

   task automatic test_reset_mid();
      mode = 1'b0; fixed_sel = 3'd2; ch_en = 8'hFF; out_ready = 8'h00;
      in_valid = 1'b1; in_data = 8'h66;
      do_reset();
      wait_ready();
      sb.push_back('{ch: 3'd2, data: 8'h66});
      step(); in_valid = 1'b0; @(negedge clk);
      total++;
      if (out_valid !== 8'h04) begin
         bad++;
         $display("FAIL rm_held: out_valid=%h, required 04", out_valid);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 8'h00 || out_data !== 8'h00 || in_ready !== 1'b0 || busy !== 1'b0 || sel !== 3'd0) begin
         bad++;
         $display("FAIL rm_async: ov=%h od=%h ir=%b busy=%b sel=%0d, required all 0",
                  out_valid, out_data, in_ready, busy, sel);
      end
      sb.delete();
      mode = 1'b1; out_ready = 8'hFF;
      step(); rst = 1'b0; @(negedge clk);
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL rm_idle: in_ready=%b, required 0", in_ready);
      end
      step(); @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || sel !== 3'd0) begin
         bad++;
         $display("FAIL rm_resume: ir=%b sel=%0d, required 1 and 0", in_ready, sel);
      end
      step();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; mode = 1'b0; fixed_sel = 3'd0;
      burst_len = 4'd0; ch_en = 8'h00; out_ready = 8'h00;
      test_reset();
      test_fixed();
      test_round_robin();
      test_backpressure();
      test_disable();
      test_corner();
      test_burst_change();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/demux_scheduler.md
DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the payload width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an upstream word is offered.
REQ-005 The block SHALL have port in_data, input, DATA_W bits: the upstream word.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = fixed channel, 1 = round-robin.
REQ-008 The block SHALL have port fixed_sel, input, 3 bits: the target channel when mode=0.
REQ-009 The block SHALL have port burst_len, input, 4 bits: words per channel before rotating in round-robin mode; value 0 SHALL be treated as 1.
REQ-010 The block SHALL have port ch_en, input, 8 bits: channel enable mask.
REQ-011 The block SHALL have port out_ready, input, 8 bits: per-channel downstream ready.
REQ-012 The block SHALL have port out_valid, output, 8 bits: one-hot per-channel valid.
REQ-013 The block SHALL have port out_data, output, DATA_W bits: payload shared by all channels.
REQ-014 The block SHALL have port sel, output, 3 bits: current target pointer.
REQ-015 The block SHALL have port busy, output, 1 bit: the holding register is occupied.

Function
REQ-016 The block SHALL contain a one-entry holding register made of hold_v, hold_d and hold_ch.
REQ-017 The block SHALL drive out_valid = onehot(hold_ch) when hold_v=1 and 8'h00 otherwise; out_data SHALL equal hold_d; busy SHALL equal hold_v.
REQ-018 An output transfer SHALL occur when hold_v=1 and out_ready[hold_ch]=1.
REQ-019 Once asserted, out_valid SHALL remain stable with hold_d and hold_ch unchanged until an output transfer occurs, regardless of changes to mode, ch_en or fixed_sel.
REQ-020 The block SHALL drive in_ready = (state==ACTIVE) && (!hold_v || output transfer), combinationally.
REQ-021 An input transfer SHALL occur when in_valid=1 and in_ready=1; it SHALL load hold_d=in_data, hold_ch=sel and hold_v=1 on the next edge, giving 1-cycle latency from input to out_valid.
REQ-022 When an input transfer and an output transfer occur in the same cycle, the holding register SHALL reload without a bubble.
REQ-023 When an output transfer occurs without an input transfer, hold_v SHALL clear on the next edge.
REQ-024 The FSM SHALL have two states: IDLE and ACTIVE.
REQ-025 IDLE->ACTIVE: if mode=0 and ch_en[fixed_sel]=1, the block SHALL set sel=fixed_sel; if mode=1 and ch_en!=0, the block SHALL set sel to the first enabled channel searching upward from sel with wrap 7->0, including sel itself. The burst count cnt SHALL be 0 on entry.
REQ-026 ACTIVE->IDLE: the transition SHALL occur on the next edge when ch_en[sel]=0, when mode=0 with fixed_sel!=sel, or when the mode input changes value. cnt SHALL clear on this transition.
REQ-027 In ACTIVE with mode=1, each input transfer SHALL increment cnt; when cnt+1 equals the effective burst length, cnt SHALL return to 0 and sel SHALL advance to the next enabled channel after sel (wrap 7->0). If sel is the only enabled channel, sel SHALL remain unchanged.
REQ-028 In ACTIVE with mode=0, cnt SHALL stay 0 and sel SHALL remain equal to fixed_sel.
REQ-029 A change to burst_len mid-burst SHALL take effect on the next comparison; if cnt+1 already exceeds the new value, rotation SHALL occur on the next input transfer.
REQ-030 While in IDLE, in_ready SHALL be 0, and a word already held SHALL still drain to its latched hold_ch.

Reset
REQ-031 While rst=1, the block SHALL force state=IDLE, sel=0, cnt=0, hold_v=0 and hold_d=0, making out_valid=0, out_data=0, in_ready=0 and busy=0.
REQ-032 Assertion of rst mid-operation SHALL discard any held word immediately without completing its transfer.
REQ-033 After rst deasserts, the block SHALL re-evaluate IDLE->ACTIVE at the first clock edge.

Verification
REQ-034 Fixed mode: with mode=0, fixed_sel=5, ch_en=FF, all out_ready=1 and in_valid continuous with data 1,2,3, out_valid SHALL equal 8'h20 every cycle, carrying data 1,2,3 with 1-cycle latency and no bubbles.
REQ-035 Round-robin: with mode=1, burst_len=2, ch_en=8'b1000_0101, all ready and 6 words streamed, the words SHALL go to channels 0,0,2,2,7,7 in order, then continue at 0.
REQ-036 Backpressure: with out_ready[3]=0 while a word is held for channel 3, out_valid SHALL stay 8'h08 with data stable, in_ready SHALL be 0, and when out_ready[3] rises the held word SHALL transfer and the next word SHALL load in the same cycle.
REQ-037 Disable: clearing ch_en[sel] mid-burst SHALL cause in_ready to fall on the next cycle, the held word to still drain, and with mode=1 the next enabled channel to be acquired after one IDLE cycle.
REQ-038 Corner cases: burst_len=0 SHALL rotate after every word; ch_en=0 SHALL keep the FSM in IDLE with in_ready=0.
REQ-039 Reset mid-transfer: asserting rst while out_valid=8'h04 SHALL drive all outputs to 0 asynchronously, and the block SHALL resume at sel=0 after release.
